reg_file: RTL and testbench

//   Integer register file for a 32-bit RISC-V core, instantiated inside the decode unit.
//   - Two combinational read ports feed rs1/rs2 operands.
//   - One synchronous write port is driven by the write-back stage.
//   - A dedicated output exposes the interrupt-handler target address, taken from a

---
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, one write port, interrupt target.
// master = decode/write-back side, slave = register file.
interface reg_file_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned ADDRESS_BITS  = 20
);
    logic [ADDRESS_WIDTH-1:0] read_sel1;
    logic [ADDRESS_WIDTH-1:0] read_sel2;
    logic                     wEn;
    logic [ADDRESS_WIDTH-1:0] write_sel;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    read_data1;
    logic [DATA_WIDTH-1:0]    read_data2;
    logic [ADDRESS_BITS-1:0]  INT_target;

    modport master (
        output read_sel1, read_sel2, wEn, write_sel, write_data,
        input  read_data1, read_data2, INT_target
    );

    modport slave (
        input  read_sel1, read_sel2, wEn, write_sel, write_data,
        output read_data1, read_data2, INT_target
    );
endinterface

// File: rtl/reg_file.sv
// RISC-V integer register file: two combinational read ports, one synchronous
// write port, x0 hard-wired to zero, and an interrupt target tap on INT_REG.
module reg_file #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned ADDRESS_BITS  = 20,
    parameter int unsigned INT_REG       = 31
) (
    input  logic       clock,
    input  logic       reset,
    reg_file_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] INT_IDX = ADDRESS_WIDTH'(INT_REG);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Next-state: a single write, with x0 writes dropped so it never leaves zero.
    always_comb begin
        regs_d = regs_q;
        if (bus.wEn && (bus.write_sel != '0)) begin
            regs_d[bus.write_sel] = bus.write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write bypass: reads see the committed array only.
    assign bus.read_data1 = (bus.read_sel1 == '0) ? '0 : regs_q[bus.read_sel1];
    assign bus.read_data2 = (bus.read_sel2 == '0) ? '0 : regs_q[bus.read_sel2];

    generate
        if (ADDRESS_BITS <= DATA_WIDTH) begin : g_int_trunc
            assign bus.INT_target = regs_q[INT_IDX][ADDRESS_BITS-1:0];
        end else begin : g_int_zext
            assign bus.INT_target = {{(ADDRESS_BITS - DATA_WIDTH){1'b0}}, regs_q[INT_IDX]};
        end
    endgenerate
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus randomized traffic
// compared against an array model of the architectural register state.
module tb_reg_file;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned AB = 20;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] model [32];

    reg_file_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_BITS(AB)) bus ();

    reg_file #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_BITS(AB), .INT_REG(31)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] sel);
        if (!reset || sel == 0) return '0;
        return model[sel];
    endfunction

    function automatic logic [AB-1:0] model_int();
        logic [DW-1:0] r;
        r = reset ? model[31] : '0;
        return r[AB-1:0];
    endfunction

    task automatic chk32(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compares every output against the model for the current selectors.
    task automatic chk_all(input string tag);
        chk32({tag, "/rd1"}, bus.read_data1, model_read(bus.read_sel1));
        chk32({tag, "/rd2"}, bus.read_data2, model_read(bus.read_sel2));
        chk32({tag, "/int"}, DW'(bus.INT_target), DW'(model_int()));
    endtask

    // Drives one cycle: check old values before the edge, new values after.
    task automatic cycle(input string tag, input logic we, input logic [AW-1:0] ws,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clock);
        bus.wEn = we; bus.write_sel = ws; bus.write_data = wd;
        bus.read_sel1 = r1; bus.read_sel2 = r2;
        #1 chk_all({tag, "/pre"});
        @(posedge clock);
        if (reset && we && ws != 0) model[ws] = wd;
        #1 chk_all({tag, "/post"});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        bus.wEn = 1'b0; bus.write_sel = '0; bus.write_data = '0;
        bus.read_sel1 = '0; bus.read_sel2 = '0;
        reset = 1'b0;
        #12;
        chk32("reset/rd1", bus.read_data1, 32'h0);
        chk32("reset/int", DW'(bus.INT_target), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Simple write to x5, read back on port 1.
        @(negedge clock);
        bus.wEn = 1'b1; bus.write_sel = 5'd5; bus.write_data = 32'hDEADBEEF;
        bus.read_sel1 = 5'd5; bus.read_sel2 = 5'd0;
        #1 chk32("x5/before", bus.read_data1, 32'h0);
        @(posedge clock); model[5] = 32'hDEADBEEF;
        #1 chk32("x5/after", bus.read_data1, 32'hDEADBEEF);

        // x0 write discarded.
        cycle("x0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk32("x0/rd1", bus.read_data1, 32'h0);
        chk32("x0/rd2", bus.read_data2, 32'h0);

        // wEn gating, then dual-port read of same register.
        cycle("x7_off", 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
        chk32("x7_off/rd1", bus.read_data1, 32'h0);
        cycle("x7_on", 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
        chk32("x7_on/rd1", bus.read_data1, 32'h12345678);
        chk32("x7_on/rd2", bus.read_data2, 32'h12345678);

        // Interrupt target truncation.
        cycle("x31", 1'b1, 5'd31, 32'hABCDE123, 5'd31, 5'd5);
        chk32("x31/int", DW'(bus.INT_target), 32'h000DE123);

        // Read-during-write on x9: old value, then new.
        cycle("x9a", 1'b1, 5'd9, 32'h11112222, 5'd9, 5'd9);
        @(negedge clock);
        bus.wEn = 1'b1; bus.write_sel = 5'd9; bus.write_data = 32'h33334444;
        #1 chk32("x9/old", bus.read_data1, 32'h11112222);
        @(posedge clock); model[9] = 32'h33334444;
        #1 chk32("x9/new", bus.read_data1, 32'h33334444);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            cycle("rand", ($urandom_range(3, 0) != 0), AW'($urandom), $urandom,
                  AW'($urandom), AW'($urandom));
        end

        // Mid-cycle async reset clears everything before any edge.
        @(negedge clock);
        bus.wEn = 1'b0; bus.read_sel1 = 5'd31; bus.read_sel2 = 5'd9;
        #2 reset = 1'b0;
        #1;
        chk32("arst/rd1", bus.read_data1, 32'h0);
        chk32("arst/rd2", bus.read_data2, 32'h0);
        chk32("arst/int", DW'(bus.INT_target), 32'h0);
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Writes ignored while reset low.
        cycle("rst_wr", 1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd31);
        @(negedge clock);
        reset = 1'b1;
        bus.wEn = 1'b0;
        #1 chk32("rst_wr/x12", bus.read_data1, 32'h0);

        // Normal writes resume after release.
        cycle("resume", 1'b1, 5'd12, 32'h0BADC0DE, 5'd12, 5'd12);
        chk32("resume/x12", bus.read_data1, 32'h0BADC0DE);
        cycle("resume31", 1'b1, 5'd31, 32'hFFF54321, 5'd31, 5'd12);
        chk32("resume31/int", DW'(bus.INT_target), 32'h00054321);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
